fir_decimator: RTL and testbench

- Sits directly downstream of fir_filter and consumes its ov_dout / o_dout_valid sample stream.
- Keeps every DECIM-th valid sample, rescales it from DATA_WIDTH to OUT_WIDTH with round-half-up and saturation, and buffers results in a small first-word-fall-through FIFO.
- The FIFO output uses a valid/ready handshake to the next stage (output interface or DAC serializer); loss of samples under backpressure is reported by a sticky overflow flag.

---
 rtl/fir_decimator.sv | 125 ++++++++++++
 tb/tb_fir_decimator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// Decimating rescaler behind fir_filter: keeps every DECIM-th accepted sample, rounds/saturates it
// to OUT_WIDTH and queues it in a first-word-fall-through FIFO with a sticky overflow flag.
module fir_decimator #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_en,
  input  logic signed [DATA_WIDTH-1:0]          iv_din,
  input  logic                                  i_din_valid,
  input  logic                                  i_ready,
  output logic signed [OUT_WIDTH-1:0]           ov_dout,
  output logic                                  o_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       ov_count,
  output logic                                  o_overflow,
  input  logic                                  i_clr_ovf
);

  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = DATA_WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SW-1:0] RND = (SHIFT > 0) ? (SW'(1) <<< RSH) : '0;
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Input side: sample accepted on i_en & i_din_valid, kept when the phase counter reads zero.
  logic [PW-1:0] r_phase;
  logic          w_accept;
  logic          w_keep;

  assign w_accept = i_en & i_din_valid;
  assign w_keep   = w_accept & (r_phase == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= '0;
    end else if (w_accept) begin
      if (r_phase == PW'(DECIM - 1)) r_phase <= '0;
      else                           r_phase <= r_phase + PW'(1);
    end
  end

  // Round-half-up: add half an LSB of the shifted result, then arithmetic shift.
  logic signed [SW-1:0]         w_ext;
  logic signed [SW-1:0]         w_rnd;
  logic signed [SW-1:0]         w_shr;
  logic [SW-OUT_WIDTH:0]        w_hi;
  logic                         w_in_range;
  logic [OUT_WIDTH-1:0]         w_sat;

  assign w_ext      = {iv_din[DATA_WIDTH-1], iv_din};
  assign w_rnd      = w_ext + RND;
  assign w_shr      = w_rnd >>> SHIFT;
  assign w_hi       = w_shr[SW-1:OUT_WIDTH-1];
  assign w_in_range = (&w_hi) | ~(|w_hi);
  assign w_sat      = w_in_range ? w_shr[OUT_WIDTH-1:0] : (w_shr[SW-1] ? SAT_MIN : SAT_MAX);

  logic [OUT_WIDTH-1:0] r_stage_data;
  logic                 r_stage_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage_data  <= '0;
      r_stage_valid <= 1'b0;
    end else begin
      r_stage_valid <= w_keep;
      if (w_keep) r_stage_data <= w_sat;
    end
  end

  // Output handshake: an entry is transferred on every clock edge where o_valid and i_ready are both
  // high; o_valid never depends on i_ready, and ov_dout is stable while o_valid is high and i_ready low.
  logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [AW-1:0]        w_head;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = o_valid & i_ready;
  assign w_push  = r_stage_valid & (~w_full | w_pop);
  assign w_drop  = r_stage_valid & w_full & ~w_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_stage_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (i_clr_ovf) r_overflow <= 1'b0;
  end

  // When empty, the slot behind the read pointer still holds the last popped entry (zero after reset).
  assign w_head     = (r_count == '0) ? (r_rptr - AW'(1)) : r_rptr;
  assign ov_dout    = r_mem[w_head];
  assign o_valid    = (r_count != '0);
  assign ov_count   = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: one instance at default parameters, one with DECIM=1
// for the rounding and saturation tables; outputs are scored against an expected queue per instance.
module tb_fir_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] din;
  logic        din_valid;
  logic        ready;
  logic        clr_ovf;

  logic [15:0] dout0, dout1;
  logic        valid0, valid1;
  logic [2:0]  count0, count1;
  logic        ovf0, ovf1;

  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];
  logic [15:0] e0, e1;
  logic        mon0_en, mon1_en;
  int          n_checks, n_fail;

  always #5 clk = ~clk;

  fir_decimator dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
    .i_ready(ready), .ov_dout(dout0), .o_valid(valid0), .ov_count(count0),
    .o_overflow(ovf0), .i_clr_ovf(clr_ovf)
  );

  fir_decimator #(.DECIM(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
    .i_ready(ready), .ov_dout(dout1), .o_valid(valid1), .ov_count(count1),
    .o_overflow(ovf1), .i_clr_ovf(clr_ovf)
  );

  // Scoreboard: a pop happens on the next rising edge whenever valid and ready are high here.
  always @(negedge clk) begin
    if (!rst && mon0_en && valid0 && ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb0_unexpected: got %0d, required no output", $signed(dout0));
      end else begin
        e0 = exp_q.pop_front();
        if (dout0 !== e0) begin
          n_fail++;
          $display("FAIL sb0_data: got %0d, required %0d", $signed(dout0), $signed(e0));
        end
      end
    end
    if (!rst && mon1_en && valid1 && ready) begin
      n_checks++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb1_unexpected: got %0d, required no output", $signed(dout1));
      end else begin
        e1 = exp1_q.pop_front();
        if (dout1 !== e1) begin
          n_fail++;
          $display("FAIL sb1_data: got %0d, required %0d", $signed(dout1), $signed(e1));
        end
      end
    end
  end

  // Drivers: all called just after a rising edge, and return just after the next one.
  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
    mon0_en = 1'b0; mon1_en = 1'b0;
    exp_q.delete(); exp1_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [23:0] d, input logic en_v);
    en = en_v; din = d; din_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    ready = 1'b0;
    for (int k = 0; k < 24; k++) drive(24'((k + 1) * 256), 1'b1);
    idle(3);
    n_checks++;
    if (count0 !== 3'd4 || valid0 !== 1'b1 || ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_precond: got count=%0d valid=%0b ovf=%0b, required 4 1 1", count0, valid0, ovf0);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b, required 0", valid0); end
    n_checks++;
    if (count0 !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", count0); end
    n_checks++;
    if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0b, required 0", ovf0); end
    n_checks++;
    if (dout0 !== 16'd0) begin n_fail++; $display("FAIL rst_dout: got %0d, required 0", dout0); end
    @(posedge clk); #1;
  endtask

  task automatic test_decimation();
    apply_reset();
    ready = 1'b1; mon0_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(24'(k * 256), 1'b1);
      if (k % 4 == 0) exp_q.push_back(16'(k));
      if (k == 0) begin
        n_checks++;
        if (valid0 !== 1'b0) begin n_fail++; $display("FAIL dec_lat_edge1: got valid=%0b, required 0", valid0); end
      end
      if (k == 1) begin
        n_checks++;
        if (valid0 !== 1'b1 || dout0 !== 16'd0) begin
          n_fail++;
          $display("FAIL dec_lat_edge2: got valid=%0b dout=%0d, required 1 0", valid0, dout0);
        end
      end
    end
    idle(4);
    n_checks++;
    if (exp_q.size() != 0 || valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_drain: got %0d pending valid=%0b, required 0 0", exp_q.size(), valid0);
    end
  endtask

  task automatic test_rounding();
    logic [23:0] vin [6] = '{24'd384, 24'd383, 24'hFFFE80, 24'hFFFE7F, 24'd127, 24'd128};
    logic [15:0] vexp[6] = '{16'd2, 16'd1, 16'hFFFF, 16'hFFFE, 16'd0, 16'd1};
    apply_reset();
    ready = 1'b1; mon1_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vin[i], 1'b1);
      exp1_q.push_back(vexp[i]);
    end
    idle(4);
    n_checks++;
    if (exp1_q.size() != 0 || valid1 !== 1'b0 || count1 !== 3'd0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d pending valid=%0b count=%0d, required 0 0 0", exp1_q.size(), valid1, count1);
    end
  endtask

  task automatic test_saturation();
    logic [23:0] vin [3] = '{24'h7FFFFF, 24'h800000, 24'h007FFF};
    logic [15:0] vexp[3] = '{16'h7FFF, 16'h8000, 16'h0080};
    apply_reset();
    ready = 1'b1; mon1_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(vin[i], 1'b1);
      exp1_q.push_back(vexp[i]);
    end
    idle(4);
    n_checks++;
    if (exp1_q.size() != 0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_drain: got %0d pending ovf=%0b, required 0 0", exp1_q.size(), ovf1);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready = 1'b0; mon0_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      drive(24'(k * 256), 1'b1);
      if (k % 4 == 0 && k < 16) exp_q.push_back(16'(k));
    end
    idle(3);
    n_checks++;
    if (count0 !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d, required 4", count0); end
    n_checks++;
    if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %0b, required 1", ovf0); end
    n_checks++;
    if (valid0 !== 1'b1 || dout0 !== 16'd0) begin
      n_fail++;
      $display("FAIL bp_head: got valid=%0b dout=%0d, required 1 0", valid0, dout0);
    end
    ready = 1'b1;
    idle(6);
    n_checks++;
    if (exp_q.size() != 0 || valid0 !== 1'b0 || count0 !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pending valid=%0b count=%0d, required 0 0 0", exp_q.size(), valid0, count0);
    end
    n_checks++;
    if (dout0 !== 16'd12) begin n_fail++; $display("FAIL bp_hold_dout: got %0d, required 12", dout0); end
    n_checks++;
    if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky: got %0b, required 1", ovf0); end
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL bp_clr_ovf: got %0b, required 0", ovf0); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    ready = 1'b0; mon0_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(24'(k * 256), 1'b1);
      if (k % 4 == 0) exp_q.push_back(16'(k));
    end
    n_checks++;
    if (count0 !== 3'd4) begin n_fail++; $display("FAIL fp_full: got %0d, required 4", count0); end
    drive(24'(16 * 256), 1'b1);
    exp_q.push_back(16'd16);
    din_valid = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    n_checks++;
    if (count0 !== 3'd4) begin n_fail++; $display("FAIL fp_count: got %0d, required 4", count0); end
    n_checks++;
    if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL fp_ovf: got %0b, required 0", ovf0); end
    ready = 1'b1;
    idle(6);
    n_checks++;
    if (exp_q.size() != 0 || valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_drain: got %0d pending valid=%0b, required 0 0", exp_q.size(), valid0);
    end
  endtask

  task automatic test_en_gating();
    apply_reset();
    ready = 1'b1; mon0_en = 1'b1;
    drive(24'd0, 1'b1);
    exp_q.push_back(16'd0);
    drive(24'd256, 1'b1);
    for (int i = 0; i < 5; i++) drive(24'h7FFFFF, 1'b0);
    idle(3);
    n_checks++;
    if (count0 !== 3'd0 || valid0 !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL en_gate: got count=%0d valid=%0b pending=%0d, required 0 0 0", count0, valid0, exp_q.size());
    end
    for (int k = 2; k < 6; k++) begin
      drive(24'(k * 256), 1'b1);
      if (k == 4) exp_q.push_back(16'd4);
    end
    idle(4);
    n_checks++;
    if (exp_q.size() != 0 || valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_resume: got %0d pending valid=%0b, required 0 0", exp_q.size(), valid0);
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
    mon0_en = 1'b0; mon1_en = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_decimation();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_en_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
